lnrv_icb_demux_ots: RTL and testbench
=====================================

Name: lnrv_icb_demux_ots

Overview:
- 1-to-N ICB demultiplexer with a registered in-order dispatch tracker of configurable depth, so several commands can be outstanding across different slaves.
- Decoding is selectable between address range and base/mask. Overlapping matches resolve to the lowest slave index.
- Unmatched addresses go to a configurable default slave or to an internal error responder.
- Sits between a core/DMA master and the peripheral/memory slaves of the bus fabric.

Parameters:
- P_ADDR_WIDTH, 32, ICB address width.
- P_DATA_WIDTH, 32, ICB data width (multiple of 8).
- P_ICB_COUNT, 4, number of slave ports (>=2).
- P_OTS_COUNT, 4, dispatch tracker depth = max outstanding commands (>=1).
- P_DECODE_MODE, "range", "range": base<=addr<end; "mask": (addr & region_end)==(base & region_end).
- P_DEFAULT_SLV, P_ICB_COUNT, slave index taking unmatched commands; value P_ICB_COUNT selects the internal error responder.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- m_icb_cmd_vld/rdy/write  in/out/in  1  master command handshake, write flag
- m_icb_cmd_addr  in  P_ADDR_WIDTH  command address
- m_icb_cmd_wdata  in  P_DATA_WIDTH  write data
- m_icb_cmd_wstrb  in  P_DATA_WIDTH/8  byte strobes
- m_icb_cmd_size  in  3  access size
- m_icb_rsp_vld/rdy  out/in  1  master response handshake
- m_icb_rsp_rdata  out  P_DATA_WIDTH  read data
- m_icb_rsp_err  out  1  response error
- sn_icb_* (cmd_vld, cmd_rdy, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cmd_size, rsp_vld, rsp_rdy, rsp_rdata, rsp_err)  out/in  per-slave field x P_ICB_COUNT, flattened, slave i at [i*W +: W]  slave ports
- sn_region_base  in  P_ADDR_WIDTH*P_ICB_COUNT  region base per slave
- sn_region_end  in  P_ADDR_WIDTH*P_ICB_COUNT  region end (range mode) or mask (mask mode)
- ots_cnt  out  $clog2(P_OTS_COUNT+1)  outstanding command count
- dec_err  out  1  one-cycle pulse on an accepted command that went to the internal error responder

Behaviour:
Reset:
- reset_n low clears the tracker immediately. Outstanding entries are discarded.
- ots_cnt=0, dec_err=0, m_icb_rsp_vld=0, all sn_icb_rsp_rdy=0.
- sn_icb_cmd_vld follows m_icb_cmd_vld combinationally and is not reset-gated.
Decode:
- Combinational from m_icb_cmd_addr. Priority one-hot, lowest index wins.
- In range mode a slave with end==0 never matches.
- No match goes to P_DEFAULT_SLV, or to the internal error target when P_DEFAULT_SLV==P_ICB_COUNT.
Command path (combinational, zero latency):
- Selected slave: vld = m_icb_cmd_vld & ~full. Address, wdata, wstrb, size and write are forwarded. Non-selected slaves receive zeros.
- m_icb_cmd_rdy = ~full & (selected slave cmd_rdy), or ~full alone for the error target.
- full = (ots_cnt==P_OTS_COUNT) & ~pop. A push into a full tracker is allowed in the same cycle as a pop.
- Handshake pushes the target index (error target encoded as P_ICB_COUNT) into the tracker FIFO.
Tracker:
- Registered FIFO, no bypass.
- ots_cnt: +1 on push, -1 on pop, unchanged on simultaneous push and pop. Pointers wrap modulo P_OTS_COUNT.
Response path, only when the tracker is non-empty (head = oldest entry):
- Head is slave h: m_icb_rsp_vld = sn_icb_rsp_vld[h], rdata and err taken from h, sn_icb_rsp_rdy[h] = m_icb_rsp_rdy. Every other rsp_rdy is 0, so non-head slaves stall and responses are returned in command order.
- Head is the error target: m_icb_rsp_vld=1, rdata=0, err=1.
- Tracker empty: m_icb_rsp_vld=0, rdata=0, err=0. A slave response asserted in the same cycle as its command handshake is forwarded from the next cycle; the slave must hold rsp_vld.
- Pop on m_icb_rsp_vld & m_icb_rsp_rdy.
dec_err:
- Registered, high for exactly one cycle after an error-target push.

Test Plan:
- Range mode, COUNT=4, regions 0x0-0x1000, 0x1000-0x2000, etc. Write to 0x1004 -> only sn_icb_cmd_vld[1] high, same-cycle rdy; slave 1 rsp (rdata 0xA5A5A5A5) -> master rsp vld, err=0; ots_cnt 1 then 0.
- Unmatched 0xF0000000 with P_DEFAULT_SLV=4 -> cmd_rdy same cycle, dec_err pulse next cycle, rsp vld next cycle with rdata=0, err=1. With P_DEFAULT_SLV=3 -> routed to slave 3.
- Commands to slave 2 then slave 0; slave 0 responds first -> sn_icb_rsp_rdy[0]=0 until slave 2 rsp handshakes; master sees slave 2 data then slave 0 data.
- OTS=2 with rsp_rdy low -> third cmd sees cmd_rdy=0, ots_cnt=2. Raise rsp_rdy: pop and push in the same cycle, ots_cnt stays 2.
- Mask mode, base 0x40000000, mask 0xF0000000 -> 0x4ABC0000 routed to that slave. Overlapping slaves 1 and 2 -> slave 1 wins.
- Assert reset_n low with 3 outstanding -> ots_cnt=0 and rsp_vld=0 asynchronously. The first post-reset command is routed normally.

Source files
------------

// File: rtl/lnrv_icb_demux_ots.sv
// rtl/lnrv_icb_demux_ots.sv - 1-to-N ICB demultiplexer with in-order outstanding tracker
// Unmatched commands go to a default slave or to an internal error responder (index P_ICB_COUNT).
module lnrv_icb_demux_ots #(
  parameter int    P_ADDR_WIDTH  = 32,
  parameter int    P_DATA_WIDTH  = 32,
  parameter int    P_ICB_COUNT   = 4,
  parameter int    P_OTS_COUNT   = 4,
  parameter string P_DECODE_MODE = "range",
  parameter int    P_DEFAULT_SLV = P_ICB_COUNT
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  m_icb_cmd_vld,
  output logic                                  m_icb_cmd_rdy,
  input  logic                                  m_icb_cmd_write,
  input  logic [P_ADDR_WIDTH-1:0]               m_icb_cmd_addr,
  input  logic [P_DATA_WIDTH-1:0]               m_icb_cmd_wdata,
  input  logic [P_DATA_WIDTH/8-1:0]             m_icb_cmd_wstrb,
  input  logic [2:0]                            m_icb_cmd_size,
  output logic                                  m_icb_rsp_vld,
  input  logic                                  m_icb_rsp_rdy,
  output logic [P_DATA_WIDTH-1:0]               m_icb_rsp_rdata,
  output logic                                  m_icb_rsp_err,
  output logic [P_ICB_COUNT-1:0]                sn_icb_cmd_vld,
  input  logic [P_ICB_COUNT-1:0]                sn_icb_cmd_rdy,
  output logic [P_ICB_COUNT-1:0]                sn_icb_cmd_write,
  output logic [P_ADDR_WIDTH*P_ICB_COUNT-1:0]   sn_icb_cmd_addr,
  output logic [P_DATA_WIDTH*P_ICB_COUNT-1:0]   sn_icb_cmd_wdata,
  output logic [P_DATA_WIDTH/8*P_ICB_COUNT-1:0] sn_icb_cmd_wstrb,
  output logic [3*P_ICB_COUNT-1:0]              sn_icb_cmd_size,
  input  logic [P_ICB_COUNT-1:0]                sn_icb_rsp_vld,
  output logic [P_ICB_COUNT-1:0]                sn_icb_rsp_rdy,
  input  logic [P_DATA_WIDTH*P_ICB_COUNT-1:0]   sn_icb_rsp_rdata,
  input  logic [P_ICB_COUNT-1:0]                sn_icb_rsp_err,
  input  logic [P_ADDR_WIDTH*P_ICB_COUNT-1:0]   sn_region_base,
  input  logic [P_ADDR_WIDTH*P_ICB_COUNT-1:0]   sn_region_end,
  output logic [$clog2(P_OTS_COUNT+1)-1:0]      ots_cnt,
  output logic                                  dec_err
);

  localparam int AW    = P_ADDR_WIDTH;
  localparam int DW    = P_DATA_WIDTH;
  localparam int SW    = P_DATA_WIDTH / 8;
  localparam int N     = P_ICB_COUNT;
  localparam int IDX_W = $clog2(N + 1);
  localparam int CNT_W = $clog2(P_OTS_COUNT + 1);
  localparam int PTR_W = (P_OTS_COUNT > 1) ? $clog2(P_OTS_COUNT) : 1;
  localparam bit MASK_MODE = (P_DECODE_MODE == "mask");

  logic [IDX_W-1:0] sel_idx;
  logic             sel_err;
  logic [AW-1:0]    reg_base;
  logic [AW-1:0]    reg_end;
  logic             hit;
  logic             slv_rdy;
  logic             full;
  logic             push;
  logic             pop;
  logic [IDX_W-1:0] head;

  logic [IDX_W-1:0] fifo_q [P_OTS_COUNT];
  logic [IDX_W-1:0] fifo_d [P_OTS_COUNT];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dec_err_q, dec_err_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(P_OTS_COUNT - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Descending scan so the lowest matching index is the last to overwrite sel_idx.
  always_comb begin
    sel_idx  = IDX_W'(P_DEFAULT_SLV);
    reg_base = '0;
    reg_end  = '0;
    hit      = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      reg_base = sn_region_base[i*AW +: AW];
      reg_end  = sn_region_end[i*AW +: AW];
      if (MASK_MODE) hit = (m_icb_cmd_addr & reg_end) == (reg_base & reg_end);
      else           hit = (reg_end != '0) && (m_icb_cmd_addr >= reg_base) && (m_icb_cmd_addr < reg_end);
      if (hit) sel_idx = IDX_W'(i);
    end
  end

  assign sel_err = (sel_idx == IDX_W'(N));
  assign head    = fifo_q[rptr_q];

  always_comb begin
    m_icb_rsp_vld   = 1'b0;
    m_icb_rsp_rdata = '0;
    m_icb_rsp_err   = 1'b0;
    sn_icb_rsp_rdy  = '0;
    if (cnt_q != '0) begin
      if (head == IDX_W'(N)) begin
        m_icb_rsp_vld = 1'b1;
        m_icb_rsp_err = 1'b1;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (head == IDX_W'(i)) begin
            m_icb_rsp_vld     = sn_icb_rsp_vld[i];
            m_icb_rsp_rdata   = sn_icb_rsp_rdata[i*DW +: DW];
            m_icb_rsp_err     = sn_icb_rsp_err[i];
            sn_icb_rsp_rdy[i] = m_icb_rsp_rdy;
          end
        end
      end
    end
  end

  assign pop  = m_icb_rsp_vld & m_icb_rsp_rdy;
  assign full = (cnt_q == CNT_W'(P_OTS_COUNT)) & ~pop;

  always_comb begin
    sn_icb_cmd_vld   = '0;
    sn_icb_cmd_write = '0;
    sn_icb_cmd_addr  = '0;
    sn_icb_cmd_wdata = '0;
    sn_icb_cmd_wstrb = '0;
    sn_icb_cmd_size  = '0;
    slv_rdy          = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sn_icb_cmd_vld[i]            = m_icb_cmd_vld & ~full;
        sn_icb_cmd_write[i]          = m_icb_cmd_write;
        sn_icb_cmd_addr[i*AW +: AW]  = m_icb_cmd_addr;
        sn_icb_cmd_wdata[i*DW +: DW] = m_icb_cmd_wdata;
        sn_icb_cmd_wstrb[i*SW +: SW] = m_icb_cmd_wstrb;
        sn_icb_cmd_size[i*3 +: 3]    = m_icb_cmd_size;
        slv_rdy                      = sn_icb_cmd_rdy[i];
      end
    end
    m_icb_cmd_rdy = ~full & (sel_err | slv_rdy);
  end

  assign push = m_icb_cmd_vld & m_icb_cmd_rdy;

  always_comb begin
    fifo_d    = fifo_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q;
    dec_err_d = push & sel_err;
    if (push) begin
      fifo_d[wptr_q] = sel_idx;
      wptr_d         = ptr_inc(wptr_q);
    end
    if (pop) rptr_d = ptr_inc(rptr_q);
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < P_OTS_COUNT; i++) fifo_q[i] <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      dec_err_q <= 1'b0;
    end else begin
      fifo_q    <= fifo_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      dec_err_q <= dec_err_d;
    end
  end

  assign ots_cnt = cnt_q;
  assign dec_err = dec_err_q;

endmodule

// File: tb/tb_lnrv_icb_demux_ots.sv
// tb/tb_lnrv_icb_demux_ots.sv - directed bench: range/error-target DUT A and mask/OTS=2 DUT B
module tb_lnrv_icb_demux_ots;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic         write = 1'b0;
  logic [31:0]  addr = '0;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = 4'hF;
  logic [2:0]   size = 3'd2;
  logic [3:0]   s_cmd_rdy = '0;
  logic [3:0]   s_rsp_vld = '0;
  logic [127:0] s_rsp_rdata = '0;
  logic [3:0]   s_rsp_err = '0;
  logic         m_rsp_rdy = 1'b0;
  logic         vld_a = 1'b0;
  logic         vld_b = 1'b0;
  logic [127:0] base_a, end_a, base_b, end_b;

  logic a_cmd_rdy, a_rsp_vld, a_rsp_err, a_dec_err;
  logic [31:0] a_rsp_rdata;
  logic [3:0] a_sn_cmd_vld, a_sn_cmd_write, a_sn_rsp_rdy;
  logic [127:0] a_sn_cmd_addr, a_sn_cmd_wdata;
  logic [15:0] a_sn_cmd_wstrb;
  logic [11:0] a_sn_cmd_size;
  logic [2:0] a_ots;

  logic b_cmd_rdy, b_rsp_vld, b_rsp_err, b_dec_err;
  logic [31:0] b_rsp_rdata;
  logic [3:0] b_sn_cmd_vld, b_sn_cmd_write, b_sn_rsp_rdy;
  logic [127:0] b_sn_cmd_addr, b_sn_cmd_wdata;
  logic [15:0] b_sn_cmd_wstrb;
  logic [11:0] b_sn_cmd_size;
  logic [1:0] b_ots;

  int checks = 0;
  int errors = 0;

  assign base_a = {32'h3000, 32'h2000, 32'h1000, 32'h0000};
  assign end_a  = {32'h4000, 32'h3000, 32'h2000, 32'h1000};
  assign base_b = {32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
  assign end_b  = {32'hFFFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'hF000_0000};

  lnrv_icb_demux_ots #(.P_OTS_COUNT(4), .P_DECODE_MODE("range"), .P_DEFAULT_SLV(4)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .m_icb_cmd_vld(vld_a), .m_icb_cmd_rdy(a_cmd_rdy), .m_icb_cmd_write(write),
    .m_icb_cmd_addr(addr), .m_icb_cmd_wdata(wdata), .m_icb_cmd_wstrb(wstrb), .m_icb_cmd_size(size),
    .m_icb_rsp_vld(a_rsp_vld), .m_icb_rsp_rdy(m_rsp_rdy), .m_icb_rsp_rdata(a_rsp_rdata), .m_icb_rsp_err(a_rsp_err),
    .sn_icb_cmd_vld(a_sn_cmd_vld), .sn_icb_cmd_rdy(s_cmd_rdy), .sn_icb_cmd_write(a_sn_cmd_write),
    .sn_icb_cmd_addr(a_sn_cmd_addr), .sn_icb_cmd_wdata(a_sn_cmd_wdata), .sn_icb_cmd_wstrb(a_sn_cmd_wstrb),
    .sn_icb_cmd_size(a_sn_cmd_size), .sn_icb_rsp_vld(s_rsp_vld), .sn_icb_rsp_rdy(a_sn_rsp_rdy),
    .sn_icb_rsp_rdata(s_rsp_rdata), .sn_icb_rsp_err(s_rsp_err),
    .sn_region_base(base_a), .sn_region_end(end_a), .ots_cnt(a_ots), .dec_err(a_dec_err)
  );

  lnrv_icb_demux_ots #(.P_OTS_COUNT(2), .P_DECODE_MODE("mask"), .P_DEFAULT_SLV(3)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .m_icb_cmd_vld(vld_b), .m_icb_cmd_rdy(b_cmd_rdy), .m_icb_cmd_write(write),
    .m_icb_cmd_addr(addr), .m_icb_cmd_wdata(wdata), .m_icb_cmd_wstrb(wstrb), .m_icb_cmd_size(size),
    .m_icb_rsp_vld(b_rsp_vld), .m_icb_rsp_rdy(m_rsp_rdy), .m_icb_rsp_rdata(b_rsp_rdata), .m_icb_rsp_err(b_rsp_err),
    .sn_icb_cmd_vld(b_sn_cmd_vld), .sn_icb_cmd_rdy(s_cmd_rdy), .sn_icb_cmd_write(b_sn_cmd_write),
    .sn_icb_cmd_addr(b_sn_cmd_addr), .sn_icb_cmd_wdata(b_sn_cmd_wdata), .sn_icb_cmd_wstrb(b_sn_cmd_wstrb),
    .sn_icb_cmd_size(b_sn_cmd_size), .sn_icb_rsp_vld(s_rsp_vld), .sn_icb_rsp_rdy(b_sn_rsp_rdy),
    .sn_icb_rsp_rdata(s_rsp_rdata), .sn_icb_rsp_err(s_rsp_err),
    .sn_region_base(base_b), .sn_region_end(end_b), .ots_cnt(b_ots), .dec_err(b_dec_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    checks++; if (a_ots !== 3'd0) begin errors++; $display("FAIL reset_ots got %0d exp 0", a_ots); end
    checks++; if (a_rsp_vld !== 1'b0) begin errors++; $display("FAIL reset_rsp_vld got %b exp 0", a_rsp_vld); end
    checks++; if (a_sn_rsp_rdy !== 4'b0) begin errors++; $display("FAIL reset_sn_rsp_rdy got %b exp 0000", a_sn_rsp_rdy); end
    checks++; if (a_dec_err !== 1'b0) begin errors++; $display("FAIL reset_dec_err got %b exp 0", a_dec_err); end
  endtask

  task automatic test_route_write;
    s_cmd_rdy = 4'hF; m_rsp_rdy = 1'b0; write = 1'b1; addr = 32'h1004; wdata = 32'h1234_5678; vld_a = 1'b1;
    #1;
    checks++; if (a_sn_cmd_vld !== 4'b0010) begin errors++; $display("FAIL route_vld got %b exp 0010", a_sn_cmd_vld); end
    checks++; if (a_cmd_rdy !== 1'b1) begin errors++; $display("FAIL route_rdy got %b exp 1", a_cmd_rdy); end
    checks++; if (a_sn_cmd_addr !== {64'h0, 32'h1004, 32'h0}) begin errors++; $display("FAIL route_addr got %h", a_sn_cmd_addr); end
    checks++; if (a_sn_cmd_wdata[63:32] !== 32'h1234_5678) begin errors++; $display("FAIL route_wdata got %h exp 12345678", a_sn_cmd_wdata[63:32]); end
    checks++; if (a_sn_cmd_write !== 4'b0010) begin errors++; $display("FAIL route_write got %b exp 0010", a_sn_cmd_write); end
    tick;
    vld_a = 1'b0; write = 1'b0;
    checks++; if (a_ots !== 3'd1) begin errors++; $display("FAIL route_ots1 got %0d exp 1", a_ots); end
    checks++; if (a_rsp_vld !== 1'b0) begin errors++; $display("FAIL route_rsp_idle got %b exp 0", a_rsp_vld); end
    s_rsp_vld = 4'b0010; s_rsp_rdata[63:32] = 32'hA5A5_A5A5; m_rsp_rdy = 1'b1;
    #1;
    checks++; if (a_rsp_vld !== 1'b1) begin errors++; $display("FAIL route_rsp_vld got %b exp 1", a_rsp_vld); end
    checks++; if (a_rsp_rdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL route_rdata got %h exp a5a5a5a5", a_rsp_rdata); end
    checks++; if (a_rsp_err !== 1'b0) begin errors++; $display("FAIL route_err got %b exp 0", a_rsp_err); end
    checks++; if (a_sn_rsp_rdy !== 4'b0010) begin errors++; $display("FAIL route_sn_rsp_rdy got %b exp 0010", a_sn_rsp_rdy); end
    tick;
    s_rsp_vld = 4'b0; m_rsp_rdy = 1'b0;
    checks++; if (a_ots !== 3'd0) begin errors++; $display("FAIL route_ots0 got %0d exp 0", a_ots); end
  endtask

  task automatic test_err_target;
    addr = 32'hF000_0000; vld_a = 1'b1; m_rsp_rdy = 1'b0;
    #1;
    checks++; if (a_cmd_rdy !== 1'b1) begin errors++; $display("FAIL err_cmd_rdy got %b exp 1", a_cmd_rdy); end
    checks++; if (a_sn_cmd_vld !== 4'b0) begin errors++; $display("FAIL err_sn_vld got %b exp 0000", a_sn_cmd_vld); end
    tick;
    vld_a = 1'b0;
    checks++; if (a_dec_err !== 1'b1) begin errors++; $display("FAIL err_dec_pulse got %b exp 1", a_dec_err); end
    checks++; if ({a_rsp_vld, a_rsp_err} !== 2'b11) begin errors++; $display("FAIL err_rsp got vld/err %b%b exp 11", a_rsp_vld, a_rsp_err); end
    checks++; if (a_rsp_rdata !== 32'h0) begin errors++; $display("FAIL err_rdata got %h exp 0", a_rsp_rdata); end
    m_rsp_rdy = 1'b1;
    tick;
    m_rsp_rdy = 1'b0;
    checks++; if (a_dec_err !== 1'b0) begin errors++; $display("FAIL err_dec_one_cycle got %b exp 0", a_dec_err); end
    checks++; if (a_ots !== 3'd0) begin errors++; $display("FAIL err_ots got %0d exp 0", a_ots); end
    checks++; if (a_rsp_vld !== 1'b0) begin errors++; $display("FAIL err_rsp_drain got %b exp 0", a_rsp_vld); end
  endtask

  task automatic test_in_order;
    vld_a = 1'b1; addr = 32'h2000;
    tick;
    addr = 32'h0010;
    tick;
    vld_a = 1'b0; m_rsp_rdy = 1'b1;
    checks++; if (a_ots !== 3'd2) begin errors++; $display("FAIL order_ots2 got %0d exp 2", a_ots); end
    s_rsp_vld = 4'b0001; s_rsp_rdata[31:0] = 32'h1111_0000;
    #1;
    checks++; if (a_rsp_vld !== 1'b0) begin errors++; $display("FAIL order_stall_vld got %b exp 0", a_rsp_vld); end
    checks++; if (a_sn_rsp_rdy !== 4'b0100) begin errors++; $display("FAIL order_stall_rdy got %b exp 0100", a_sn_rsp_rdy); end
    tick;
    checks++; if (a_ots !== 3'd2) begin errors++; $display("FAIL order_hold_ots got %0d exp 2", a_ots); end
    s_rsp_vld = 4'b0101; s_rsp_rdata[95:64] = 32'h2222_0000;
    #1;
    checks++; if (a_rsp_rdata !== 32'h2222_0000) begin errors++; $display("FAIL order_first got %h exp 22220000", a_rsp_rdata); end
    tick;
    s_rsp_vld = 4'b0001;
    #1;
    checks++; if (a_rsp_rdata !== 32'h1111_0000) begin errors++; $display("FAIL order_second got %h exp 11110000", a_rsp_rdata); end
    checks++; if (a_sn_rsp_rdy !== 4'b0001) begin errors++; $display("FAIL order_second_rdy got %b exp 0001", a_sn_rsp_rdy); end
    tick;
    s_rsp_vld = 4'b0; m_rsp_rdy = 1'b0;
    checks++; if (a_ots !== 3'd0) begin errors++; $display("FAIL order_drain got %0d exp 0", a_ots); end
  endtask

  task automatic test_reset_outstanding;
    vld_a = 1'b1; addr = 32'h1000; m_rsp_rdy = 1'b0;
    tick; tick; tick;
    vld_a = 1'b0;
    checks++; if (a_ots !== 3'd3) begin errors++; $display("FAIL rst_pre_ots got %0d exp 3", a_ots); end
    s_rsp_vld = 4'b0010;
    #1;
    checks++; if (a_rsp_vld !== 1'b1) begin errors++; $display("FAIL rst_pre_vld got %b exp 1", a_rsp_vld); end
    reset_n = 1'b0;
    #1;
    checks++; if (a_ots !== 3'd0) begin errors++; $display("FAIL rst_async_ots got %0d exp 0", a_ots); end
    checks++; if (a_rsp_vld !== 1'b0) begin errors++; $display("FAIL rst_async_vld got %b exp 0", a_rsp_vld); end
    tick;
    reset_n = 1'b1; s_rsp_vld = 4'b0; addr = 32'h3000; vld_a = 1'b1;
    #1;
    checks++; if (a_sn_cmd_vld !== 4'b1000) begin errors++; $display("FAIL rst_post_route got %b exp 1000", a_sn_cmd_vld); end
    tick;
    vld_a = 1'b0;
    checks++; if (a_ots !== 3'd1) begin errors++; $display("FAIL rst_post_ots got %0d exp 1", a_ots); end
    s_rsp_vld = 4'b1000; m_rsp_rdy = 1'b1;
    tick;
    s_rsp_vld = 4'b0; m_rsp_rdy = 1'b0;
    checks++; if (a_ots !== 3'd0) begin errors++; $display("FAIL rst_post_drain got %0d exp 0", a_ots); end
  endtask

  task automatic test_mask_decode;
    vld_b = 1'b1; s_cmd_rdy = 4'hF; addr = 32'h4ABC_0000;
    #1;
    checks++; if (b_sn_cmd_vld !== 4'b0001) begin errors++; $display("FAIL mask_s0 got %b exp 0001", b_sn_cmd_vld); end
    addr = 32'h8000_1234;
    #1;
    checks++; if (b_sn_cmd_vld !== 4'b0010) begin errors++; $display("FAIL mask_overlap got %b exp 0010", b_sn_cmd_vld); end
    addr = 32'hC000_0000;
    #1;
    checks++; if (b_sn_cmd_vld !== 4'b0100) begin errors++; $display("FAIL mask_s2 got %b exp 0100", b_sn_cmd_vld); end
    addr = 32'h1000_0000;
    #1;
    checks++; if (b_sn_cmd_vld !== 4'b1000) begin errors++; $display("FAIL mask_default got %b exp 1000", b_sn_cmd_vld); end
    tick;
    vld_b = 1'b0;
    checks++; if (b_dec_err !== 1'b0) begin errors++; $display("FAIL mask_default_dec got %b exp 0", b_dec_err); end
    checks++; if (b_ots !== 2'd1) begin errors++; $display("FAIL mask_ots got %0d exp 1", b_ots); end
    s_rsp_vld = 4'b1000; m_rsp_rdy = 1'b1;
    tick;
    s_rsp_vld = 4'b0; m_rsp_rdy = 1'b0;
    checks++; if (b_ots !== 2'd0) begin errors++; $display("FAIL mask_drain got %0d exp 0", b_ots); end
  endtask

  task automatic test_ots_full;
    m_rsp_rdy = 1'b0; s_rsp_vld = 4'b0; addr = 32'h4000_0000; vld_b = 1'b1;
    tick; tick;
    addr = 32'h4000_0004;
    #1;
    checks++; if (b_cmd_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy got %b exp 0", b_cmd_rdy); end
    checks++; if (b_ots !== 2'd2) begin errors++; $display("FAIL full_ots got %0d exp 2", b_ots); end
    checks++; if (b_sn_cmd_vld !== 4'b0) begin errors++; $display("FAIL full_sn_vld got %b exp 0000", b_sn_cmd_vld); end
    s_rsp_vld = 4'b0001; m_rsp_rdy = 1'b1;
    #1;
    checks++; if (b_cmd_rdy !== 1'b1) begin errors++; $display("FAIL full_poppush_rdy got %b exp 1", b_cmd_rdy); end
    tick;
    vld_b = 1'b0;
    checks++; if (b_ots !== 2'd2) begin errors++; $display("FAIL full_poppush_ots got %0d exp 2", b_ots); end
    tick; tick;
    s_rsp_vld = 4'b0; m_rsp_rdy = 1'b0;
    checks++; if (b_ots !== 2'd0) begin errors++; $display("FAIL full_drain got %0d exp 0", b_ots); end
  endtask

  initial begin
    tick; tick;
    reset_n = 1'b1;
    tick;
    test_reset();
    test_route_write();
    test_err_target();
    test_in_order();
    test_reset_outstanding();
    test_mask_decode();
    test_ots_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
